// File: rtl/key_search_scheduler.sv
// Key search scheduler: hands out RC4 candidate keys to a pool of decryption
// cores with round-robin arbitration, tracks each core's outstanding key, and
// stops the search on the first found key or when the key range is used up.
module key_search_scheduler #(
  parameter int               NUM_CORES = 4,
  parameter int               KEY_W     = 24,
  parameter logic [KEY_W-1:0] KEY_FIRST = 24'h000000,
  parameter logic [KEY_W-1:0] KEY_LAST  = 24'h3FFFFF,
  localparam int              CW        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_CORES-1:0] key_req,
  output logic [NUM_CORES-1:0] key_grant,
  output logic [KEY_W-1:0]     key_out,
  input  logic [NUM_CORES-1:0] core_done,
  input  logic [NUM_CORES-1:0] core_found,
  output logic                 abort,
  output logic                 busy,
  output logic                 found,
  output logic                 not_found,
  output logic [KEY_W-1:0]     found_key,
  output logic [CW-1:0]        found_core
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FOUND,
    S_EXHAUSTED
  } state_t;

  state_t               state_reg;
  // One extra bit so that a KEY_LAST of all-ones steps past the range
  // instead of wrapping back to zero.
  logic [KEY_W:0]       next_key_reg;
  logic [NUM_CORES-1:0] outstanding_reg;
  logic [CW-1:0]        ptr_reg;
  logic [KEY_W-1:0]     key_mem [NUM_CORES];

  logic [NUM_CORES-1:0] done_hit;
  logic [NUM_CORES-1:0] found_hit;
  logic [NUM_CORES-1:0] outstanding_after;
  logic [NUM_CORES-1:0] eligible;
  logic                 keys_left;
  logic                 last_key;

  // Done pulses only count for cores that actually hold a key; a core that
  // finishes this cycle may be handed a new key in the same cycle.
  assign done_hit          = core_done & outstanding_reg;
  assign found_hit         = done_hit & core_found;
  assign outstanding_after = outstanding_reg & ~done_hit;
  assign eligible          = key_req & ~outstanding_after;
  assign keys_left         = (next_key_reg <= {1'b0, KEY_LAST});
  assign last_key          = (next_key_reg >= {1'b0, KEY_LAST});

  logic          any_found;
  logic [CW-1:0] win_idx;

  // Lowest-indexed core reporting success wins a simultaneous find.
  always_comb begin
    any_found = 1'b0;
    win_idx   = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (found_hit[i]) begin
        any_found = 1'b1;
        win_idx   = CW'(i);
      end
    end
  end

  logic                 grant_any;
  logic [CW-1:0]        grant_idx;
  logic [NUM_CORES-1:0] grant_onehot;

  // Round-robin pick: first eligible core at or after the pointer.
  always_comb begin : rr_search
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!grant_any && eligible[idx]) begin
        grant_any = 1'b1;
        grant_idx = CW'(idx);
      end
    end
    grant_onehot = NUM_CORES'(1) << grant_idx;
  end

  // Search control FSM with registered outputs and per-core key records.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      next_key_reg    <= {1'b0, KEY_FIRST};
      outstanding_reg <= '0;
      ptr_reg         <= '0;
      key_grant       <= '0;
      key_out         <= '0;
      abort           <= 1'b0;
      busy            <= 1'b0;
      found           <= 1'b0;
      not_found       <= 1'b0;
      found_key       <= '0;
      found_core      <= '0;
    end else begin
      key_grant <= '0;
      case (state_reg)
        S_IDLE, S_FOUND, S_EXHAUSTED: begin
          if (start) begin
            state_reg       <= S_RUN;
            next_key_reg    <= {1'b0, KEY_FIRST};
            outstanding_reg <= '0;
            busy            <= 1'b1;
            abort           <= 1'b0;
            found           <= 1'b0;
            not_found       <= 1'b0;
          end
        end
        S_RUN, S_DRAIN: begin
          outstanding_reg <= outstanding_after;
          if (any_found) begin
            state_reg  <= S_FOUND;
            found      <= 1'b1;
            abort      <= 1'b1;
            busy       <= 1'b0;
            found_key  <= key_mem[win_idx];
            found_core <= win_idx;
          end else if (state_reg == S_RUN) begin
            if (grant_any && keys_left) begin
              key_grant          <= grant_onehot;
              key_out            <= next_key_reg[KEY_W-1:0];
              key_mem[grant_idx] <= next_key_reg[KEY_W-1:0];
              outstanding_reg    <= outstanding_after | grant_onehot;
              next_key_reg       <= next_key_reg + 1'b1;
              ptr_reg            <= (int'(grant_idx) == NUM_CORES - 1) ? '0 : CW'(grant_idx + 1'b1);
              if (last_key) state_reg <= S_DRAIN;
            end else if (!keys_left) begin
              state_reg <= S_DRAIN;
            end
          end else if (outstanding_after == '0) begin
            state_reg <= S_EXHAUSTED;
            not_found <= 1'b1;
            abort     <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_search_scheduler.sv
// Bench for key_search_scheduler: directed scenarios with literal expectations,
// then randomized searches checked every cycle against a behavioural model.
module tb_key_search_scheduler;

  localparam int N    = 4;
  localparam int LAST = 63;

  logic        clk = 1'b0;
  logic        reset = 1'b1, start = 1'b0;
  logic [3:0]  key_req = '0, core_done = '0, core_found = '0;
  logic [3:0]  key_grant;
  logic [23:0] key_out, found_key;
  logic        abort, busy, found, not_found;
  logic [1:0]  found_core;

  logic        reset1 = 1'b1, start1 = 1'b0, req1 = 1'b0, done1 = 1'b0, fnd1 = 1'b0;
  logic        grant1, abort1, busy1, found1, nf1;
  logic [23:0] key1, fkey1;
  logic [0:0]  fcore1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  key_search_scheduler #(.NUM_CORES(4), .KEY_W(24), .KEY_FIRST(24'h000000), .KEY_LAST(24'h00003F)) u0 (
    .clk(clk), .reset(reset), .start(start), .key_req(key_req), .key_grant(key_grant),
    .key_out(key_out), .core_done(core_done), .core_found(core_found), .abort(abort),
    .busy(busy), .found(found), .not_found(not_found), .found_key(found_key), .found_core(found_core)
  );

  key_search_scheduler #(.NUM_CORES(1), .KEY_W(24), .KEY_FIRST(24'hFFFFFE), .KEY_LAST(24'hFFFFFF)) u1 (
    .clk(clk), .reset(reset1), .start(start1), .key_req(req1), .key_grant(grant1),
    .key_out(key1), .core_done(done1), .core_found(fnd1), .abort(abort1),
    .busy(busy1), .found(found1), .not_found(nf1), .found_key(fkey1), .found_core(fcore1)
  );

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model of u0 ----------------
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_FOUND = 3, M_EXH = 4;
  int         ms = M_IDLE;
  int         m_next = 0, m_ptr = 0;
  bit         m_out [N];
  int         m_rec [N];
  logic [3:0] e_grant = '0;
  int         e_key = 0, e_fkey = 0, e_fcore = 0;
  bit         e_busy = 0, e_abort = 0, e_found = 0, e_nf = 0;

  always @(posedge clk) begin
    int win, pick, c;
    bit any_out;
    e_grant = '0;
    if (reset) begin
      ms = M_IDLE; m_ptr = 0; m_next = 0;
      for (int i = 0; i < N; i++) m_out[i] = 0;
      e_busy = 0; e_abort = 0; e_found = 0; e_nf = 0; e_key = 0; e_fkey = 0; e_fcore = 0;
    end else if (ms == M_IDLE || ms == M_FOUND || ms == M_EXH) begin
      if (start) begin
        ms = M_RUN; m_next = 0;
        for (int i = 0; i < N; i++) m_out[i] = 0;
        e_busy = 1; e_abort = 0; e_found = 0; e_nf = 0;
      end
    end else begin
      win = -1;
      for (int i = 0; i < N; i++)
        if (core_done[i] && m_out[i]) begin
          m_out[i] = 0;
          if (core_found[i] && win < 0) win = i;
        end
      if (win >= 0) begin
        ms = M_FOUND; e_found = 1; e_abort = 1; e_busy = 0;
        e_fkey = m_rec[win]; e_fcore = win;
      end else if (ms == M_RUN) begin
        pick = -1;
        if (m_next <= LAST)
          for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (pick < 0 && key_req[c] && !m_out[c]) pick = c;
          end
        if (pick >= 0) begin
          e_grant[pick] = 1'b1; e_key = m_next; m_rec[pick] = m_next;
          m_out[pick] = 1; m_next++; m_ptr = (pick + 1) % N;
        end
        if (m_next > LAST) ms = M_DRAIN;
      end else begin
        any_out = 0;
        for (int i = 0; i < N; i++) any_out |= m_out[i];
        if (!any_out) begin
          ms = M_EXH; e_nf = 1; e_abort = 1; e_busy = 0;
        end
      end
    end
  end

  // Compare u0 against the model on every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("m_grant", 32'(key_grant), 32'(e_grant));
    if (e_grant != 0) chk("m_key_out", 32'(key_out), e_key);
    chk("m_busy", 32'(busy), 32'(e_busy));
    chk("m_abort", 32'(abort), 32'(e_abort));
    chk("m_found", 32'(found), 32'(e_found));
    chk("m_not_found", 32'(not_found), 32'(e_nf));
    if (e_found) begin
      chk("m_found_key", 32'(found_key), e_fkey);
      chk("m_found_core", 32'(found_core), e_fcore);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  bit  hold [N];
  int  hkey [N];
  int  lat  [N];
  bit  granted [64];
  int  gcount, target;
  bit  ended, fresh;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk("rst_grant", 32'(key_grant), 0);
    chk("rst_key_out", 32'(key_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_abort", 32'(abort), 0);
    chk("rst_found", 32'(found), 0);
    chk("rst_not_found", 32'(not_found), 0);
    chk("rst_found_key", 32'(found_key), 0);
    chk("rst_found_core", 32'(found_core), 0);

    // Four cores requesting continuously: cores 0..3 get keys 0..3.
    reset = 0; start = 1; key_req = 4'hF;
    tick(); start = 0;
    chk("run_busy", 32'(busy), 1);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("rr_grant", 32'(key_grant), 32'(1) << c);
      chk("rr_key", 32'(key_out), c);
    end
    tick();
    chk("fifth_waits", 32'(key_grant), 0);
    core_done = 4'b0010;
    tick(); core_done = 0;
    chk("regrant_core", 32'(key_grant), 32'h2);
    chk("regrant_key", 32'(key_out), 4);

    // Cores 1 and 3 find simultaneously: core 1 (key 4) wins.
    core_done = 4'b1010; core_found = 4'b1010; key_req = 0;
    tick(); core_done = 0; core_found = 0;
    chk("dual_found", 32'(found), 1);
    chk("dual_core", 32'(found_core), 1);
    chk("dual_key", 32'(found_key), 4);
    chk("dual_abort", 32'(abort), 1);
    chk("dual_busy", 32'(busy), 0);
    chk("dual_no_grant", 32'(key_grant), 0);

    // Core 2 alone walks keys 0..0x2A and reports success on 0x2A.
    start = 1; key_req = 4'b0100;
    tick(); start = 0;
    chk("restart_found_clr", 32'(found), 0);
    for (int k = 0; k <= 42; k++) begin
      tick();
      chk("seq_grant", 32'(key_grant), 32'h4);
      chk("seq_key", 32'(key_out), k);
      core_done = 4'b0100;
      core_found = (k == 42) ? 4'b0100 : 4'b0000;
    end
    tick(); core_done = 0; core_found = 0;
    chk("f2a_found", 32'(found), 1);
    chk("f2a_key", 32'(found_key), 32'h2A);
    chk("f2a_core", 32'(found_core), 2);
    chk("f2a_abort", 32'(abort), 1);
    chk("f2a_no_grant", 32'(key_grant), 0);
    key_req = 0;
    tick();
    chk("f2a_after_no_grant", 32'(key_grant), 0);

    // Reset with three keys outstanding, then stale dones are ignored.
    start = 1; key_req = 4'hF;
    tick(); start = 0;
    tick(); tick(); tick();
    chk("pre_rst_key", 32'(key_out), 2);
    key_req = 0; reset = 1;
    tick();
    chk("midrst_grant", 32'(key_grant), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_key_out", 32'(key_out), 0);
    reset = 0;
    tick(); start = 1;
    tick(); start = 0; core_done = 4'hF; core_found = 4'hF;
    tick(); core_done = 0; core_found = 0;
    chk("stale_done_ignored", 32'(found), 0);
    chk("stale_busy", 32'(busy), 1);
    key_req = 4'hF;
    tick();
    chk("rst_restart_grant", 32'(key_grant), 1);
    chk("rst_restart_key", 32'(key_out), 0);
    key_req = 0; reset = 1;
    tick(); tick();
    reset = 0;

    // Single core at the top of the key space: FFFFFE, FFFFFF, no wrap.
    reset1 = 0; start1 = 1; req1 = 1;
    tick(); start1 = 0;
    chk("u1_busy", 32'(busy1), 1);
    tick();
    chk("u1_grant0", 32'(grant1), 1);
    chk("u1_key0", 32'(key1), 32'hFFFFFE);
    req1 = 0;
    tick();
    chk("u1_hold", 32'(grant1), 0);
    tick();
    done1 = 1; req1 = 1;
    tick(); done1 = 0;
    chk("u1_grant1", 32'(grant1), 1);
    chk("u1_key1", 32'(key1), 32'hFFFFFF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("u1_no_wrap", 32'(grant1), 0);
      chk("u1_drain_busy", 32'(busy1), 1);
    end
    req1 = 0; done1 = 1;
    tick(); done1 = 0;
    chk("u1_not_found", 32'(nf1), 1);
    chk("u1_abort", 32'(abort1), 1);
    chk("u1_busy_end", 32'(busy1), 0);
    chk("u1_found", 32'(found1), 0);

    // Randomized searches on u0.
    for (int s = 0; s < 8; s++) begin
      target = ($urandom_range(0, 2) == 0) ? 999 : int'($urandom_range(0, LAST));
      for (int i = 0; i < 64; i++) granted[i] = 0;
      for (int i = 0; i < N; i++) hold[i] = 0;
      gcount = 0; ended = 0;
      start = 1;
      for (int cyc = 0; cyc < 3000 && !ended; cyc++) begin
        tick();
        start = 0;
        if (found || not_found) begin
          ended = 1;
        end else begin
          for (int i = 0; i < N; i++) begin
            fresh = 0;
            core_done[i] = 0; core_found[i] = 0;
            if (key_grant[i]) begin
              hold[i] = 1; hkey[i] = int'(key_out); lat[i] = $urandom_range(0, 5); fresh = 1;
              if (key_out < 64) begin
                chk("dup_grant", 32'(granted[key_out]), 0);
                granted[key_out] = 1;
              end
              gcount++;
            end
            if (hold[i] && !fresh) begin
              if (lat[i] == 0) begin
                core_done[i] = 1; core_found[i] = (hkey[i] == target); hold[i] = 0;
              end else lat[i]--;
            end else if (!hold[i] && $urandom_range(0, 24) == 0) begin
              core_done[i] = 1; core_found[i] = $urandom_range(0, 1) == 1;
            end
            key_req[i] = !hold[i] && !abort && ($urandom_range(0, 3) != 0);
          end
          start = busy && ($urandom_range(0, 39) == 0);
        end
      end
      key_req = 0; core_done = 0; core_found = 0; start = 0;
      if (!ended) chk("search_timeout", 0, 1);
      else if (found) begin
        chk("rnd_found_key", 32'(found_key), target);
      end else begin
        chk("rnd_exhaust_target", target, 999);
        chk("rnd_exhaust_count", gcount, 64);
      end
      repeat ($urandom_range(1, 4)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
